// File: rtl/trigger_pkg.sv
// trigger_pkg: definitions shared by the DI2C trigger transmitter and receiver.
//   - state encoding of the transmitter FSM
//   - frame geometry (byte count, SCL slots per byte)
//   - on-wire byte order
//   - CRC word sequencing and the byte-wise bit reversal used when feeding
//     the MSB-first crc16_generator so that the result is CRC16-KERMIT
package trigger_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_BUSY = 3'd1,
    ST_CRC       = 3'd2,
    ST_START     = 3'd3,
    ST_BITS      = 3'd4,
    ST_STOP      = 3'd5,
    ST_GAP       = 3'd6
  } tx_state_e;

  localparam int FRAME_BYTES        = 8;
  localparam int BITS_PER_BYTE_SLOT = 9;

  // Position of each field in the transmitted frame.
  localparam logic [2:0] BYTE_ID     = 3'd0;
  localparam logic [2:0] BYTE_TYPE   = 3'd1;
  localparam logic [2:0] BYTE_SER3   = 3'd2;
  localparam logic [2:0] BYTE_SER2   = 3'd3;
  localparam logic [2:0] BYTE_SER1   = 3'd4;
  localparam logic [2:0] BYTE_SER0   = 3'd5;
  localparam logic [2:0] BYTE_CRC_HI = 3'd6;
  localparam logic [2:0] BYTE_CRC_LO = 3'd7;

  localparam logic [2:0] LAST_BYTE = 3'(FRAME_BYTES - 1);
  localparam logic [3:0] LAST_SLOT = 4'(BITS_PER_BYTE_SLOT - 1);

  // CRC sequencing steps: clear the generator, feed three words, latch.
  localparam logic [2:0] CRC_STEP_CLEAR = 3'd0;
  localparam logic [2:0] CRC_STEP_W0    = 3'd1;
  localparam logic [2:0] CRC_STEP_W1    = 3'd2;
  localparam logic [2:0] CRC_STEP_W2    = 3'd3;
  localparam logic [2:0] CRC_STEP_LATCH = 3'd4;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7 - i];
    end
    return r;
  endfunction

  function automatic logic [15:0] rev16(input logic [15:0] w);
    logic [15:0] r;
    r = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      r[i] = w[15 - i];
    end
    return r;
  endfunction

  // Reflected-input CRC on an MSB-first engine: reverse bits inside each
  // byte, keep the byte order.
  function automatic logic [15:0] crc_word(input logic [15:0] w);
    return {rev8(w[15:8]), rev8(w[7:0])};
  endfunction

endpackage

// File: rtl/trigger_tx_if.sv
// trigger_tx_if: request/status bundle between a trigger source and trigger_tx.
//   trig_req/sub_system_id/trigger_type/serial_clear : source -> transmitter
//   trig_ack/frame_done/busy_timeout/tx_active/trigger_serial : transmitter -> source
interface trigger_tx_if;
  logic        trig_req;
  logic [7:0]  sub_system_id;
  logic [7:0]  trigger_type;
  logic        serial_clear;
  logic        trig_ack;
  logic        frame_done;
  logic        busy_timeout;
  logic        tx_active;
  logic [31:0] trigger_serial;

  modport master (
    output trig_req, sub_system_id, trigger_type, serial_clear,
    input  trig_ack, frame_done, busy_timeout, tx_active, trigger_serial
  );

  modport slave (
    input  trig_req, sub_system_id, trigger_type, serial_clear,
    output trig_ack, frame_done, busy_timeout, tx_active, trigger_serial
  );
endinterface

// File: rtl/crc16_generator.sv
// crc16_generator: MSB-first CRC16 engine, polynomial 0x1021, init 0x0000.
//   clock      : clock
//   reset      : synchronous clear of the CRC register
//   data_in_en : consume data_in this cycle (16 bits, bit 15 first)
//   data_in    : input word
//   crc_out    : current CRC register value
module crc16_generator (
  input  logic        clock,
  input  logic        reset,
  input  logic        data_in_en,
  input  logic [15:0] data_in,
  output logic [15:0] crc_out
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;

  function automatic logic [15:0] crc_step16(input logic [15:0] crc, input logic [15:0] d);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  // Next CRC value: advance by one word when enabled.
  always_comb begin
    crc_d = crc_q;
    if (data_in_en) begin
      crc_d = crc_step16(crc_q, data_in);
    end else begin
      crc_d = crc_q;
    end
  end

  // CRC register with synchronous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      crc_q <= 16'h0000;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_out = crc_q;

endmodule

// File: rtl/trigger_tx.sv
// trigger_tx: DI2C trigger-link transmitter.
//   clk, reset            : system clock, synchronous active-high reset
//   ctl (trigger_tx_if)   : trigger request in, ack/done/timeout/active/serial out
//   *_sda, *_scl          : driven transceivers (ren=1, de=1, di = line level)
//   *_busy                : receive-only transceiver, ro_busy is the sub-system busy
// A request waits for busy low, computes CRC16-KERMIT over id/type/serial,
// then sends start, 8 bytes (9 SCL slots each, last slot a 0 dummy), stop,
// and holds the bus idle for GAP_CYCLES before the serial advances.
module trigger_tx
  import trigger_pkg::*;
#(
  parameter int HALF_PERIOD  = 50,
  parameter int BUSY_TIMEOUT = 1000000,
  parameter int GAP_CYCLES   = 200
) (
  input  logic   clk,
  input  logic   reset,
  trigger_tx_if.slave ctl,
  input  logic   ro_sda,
  output logic   ren_sda,
  output logic   de_sda,
  output logic   di_sda,
  input  logic   ro_scl,
  output logic   ren_scl,
  output logic   de_scl,
  output logic   di_scl,
  input  logic   ro_busy,
  output logic   ren_busy,
  output logic   de_busy,
  output logic   di_busy
);

  localparam logic [15:0] HP_LAST   = 16'(HALF_PERIOD - 1);
  localparam logic [31:0] WAIT_LAST = 32'(BUSY_TIMEOUT - 1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);

  tx_state_e   state_q, state_d;
  logic [31:0] serial_q, serial_d;
  logic [7:0]  id_q, id_d;
  logic [7:0]  type_q, type_d;
  logic [31:0] cnt_q, cnt_d;        // busy wait / gap counter
  logic [15:0] half_q, half_d;      // cycle within an SCL half-period
  logic        phase_q, phase_d;    // 0: SCL low half, 1: SCL high half
  logic [3:0]  slot_q, slot_d;      // SCL slot within the current byte
  logic [2:0]  byte_q, byte_d;
  logic [2:0]  crc_step_q, crc_step_d;
  logic [15:0] crc_q, crc_d;
  logic        scl_q, scl_d;
  logic        sda_q, sda_d;
  logic        ack_q, ack_d;
  logic        done_q, done_d;
  logic        to_q, to_d;
  logic        active_q, active_d;
  logic        busy_m_q, busy_s_q;

  logic        crc_clr;
  logic        crc_en;
  logic [15:0] crc_din;
  logic [15:0] crc_out;
  logic [7:0]  cur_byte;
  logic [2:0]  bit_sel;
  logic        tx_bit;
  logic        unused_inputs;

  assign unused_inputs = ro_sda ^ ro_scl;

  crc16_generator u_crc (
    .clock      (clk),
    .reset      (crc_clr | reset),
    .data_in_en (crc_en),
    .data_in    (crc_din),
    .crc_out    (crc_out)
  );

  // Byte currently on the wire and the bit for the current SCL slot.
  always_comb begin
    cur_byte = 8'h00;
    case (byte_q)
      BYTE_ID:     cur_byte = id_q;
      BYTE_TYPE:   cur_byte = type_q;
      BYTE_SER3:   cur_byte = serial_q[31:24];
      BYTE_SER2:   cur_byte = serial_q[23:16];
      BYTE_SER1:   cur_byte = serial_q[15:8];
      BYTE_SER0:   cur_byte = serial_q[7:0];
      BYTE_CRC_HI: cur_byte = crc_q[15:8];
      BYTE_CRC_LO: cur_byte = crc_q[7:0];
      default:     cur_byte = 8'h00;
    endcase
    bit_sel = 3'd7 - slot_q[2:0];
    if (slot_q == LAST_SLOT) begin
      tx_bit = 1'b0;
    end else begin
      tx_bit = cur_byte[bit_sel];
    end
  end

  // Next-state, datapath and output decode for the transmit FSM.
  always_comb begin
    state_d    = state_q;
    serial_d   = serial_q;
    id_d       = id_q;
    type_d     = type_q;
    cnt_d      = cnt_q;
    half_d     = half_q;
    phase_d    = phase_q;
    slot_d     = slot_q;
    byte_d     = byte_q;
    crc_step_d = crc_step_q;
    crc_d      = crc_q;
    scl_d      = scl_q;
    sda_d      = sda_q;
    ack_d      = 1'b0;
    done_d     = 1'b0;
    to_d       = 1'b0;
    active_d   = active_q;
    crc_clr    = 1'b0;
    crc_en     = 1'b0;
    crc_din    = 16'h0000;

    case (state_q)
      ST_IDLE: begin
        scl_d = 1'b1;
        sda_d = 1'b1;
        // Clear lands before a simultaneous request so that frame carries 0.
        if (ctl.serial_clear) begin
          serial_d = 32'h0000_0000;
        end else begin
          serial_d = serial_q;
        end
        if (ctl.trig_req) begin
          state_d  = ST_WAIT_BUSY;
          ack_d    = 1'b1;
          active_d = 1'b1;
          id_d     = ctl.sub_system_id;
          type_d   = ctl.trigger_type;
          cnt_d    = 32'd0;
        end else begin
          active_d = 1'b0;
        end
      end

      ST_WAIT_BUSY: begin
        if (!busy_s_q) begin
          state_d    = ST_CRC;
          crc_step_d = CRC_STEP_CLEAR;
        end else if (cnt_q == WAIT_LAST) begin
          to_d     = 1'b1;
          active_d = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      ST_CRC: begin
        crc_step_d = crc_step_q + 3'd1;
        case (crc_step_q)
          CRC_STEP_CLEAR: crc_clr = 1'b1;
          CRC_STEP_W0: begin
            crc_en  = 1'b1;
            crc_din = crc_word({id_q, type_q});
          end
          CRC_STEP_W1: begin
            crc_en  = 1'b1;
            crc_din = crc_word(serial_q[31:16]);
          end
          CRC_STEP_W2: begin
            crc_en  = 1'b1;
            crc_din = crc_word(serial_q[15:0]);
          end
          CRC_STEP_LATCH: begin
            // Engine register is non-reflected; KERMIT wants it mirrored.
            crc_d      = rev16(crc_out);
            crc_step_d = CRC_STEP_CLEAR;
            state_d    = ST_START;
            sda_d      = 1'b0;
            half_d     = 16'd0;
          end
          default: begin
            crc_step_d = CRC_STEP_CLEAR;
            state_d    = ST_IDLE;
            active_d   = 1'b0;
          end
        endcase
      end

      ST_START: begin
        if (half_q == HP_LAST) begin
          scl_d   = 1'b0;
          half_d  = 16'd0;
          phase_d = 1'b0;
          slot_d  = 4'd0;
          byte_d  = 3'd0;
          state_d = ST_BITS;
        end else begin
          half_d = half_q + 16'd1;
        end
      end

      ST_BITS: begin
        if (!phase_q) begin
          // SDA is updated at the end of the first SCL-low cycle only.
          if (half_q == 16'd0) begin
            sda_d = tx_bit;
          end else begin
            sda_d = sda_q;
          end
          if (half_q == HP_LAST) begin
            scl_d   = 1'b1;
            phase_d = 1'b1;
            half_d  = 16'd0;
          end else begin
            half_d = half_q + 16'd1;
          end
        end else begin
          if (half_q == HP_LAST) begin
            scl_d   = 1'b0;
            phase_d = 1'b0;
            half_d  = 16'd0;
            if (slot_q == LAST_SLOT) begin
              slot_d = 4'd0;
              if (byte_q == LAST_BYTE) begin
                state_d = ST_STOP;
              end else begin
                byte_d = byte_q + 3'd1;
              end
            end else begin
              slot_d = slot_q + 4'd1;
            end
          end else begin
            half_d = half_q + 16'd1;
          end
        end
      end

      ST_STOP: begin
        if (!phase_q) begin
          if (half_q == 16'd0) begin
            sda_d = 1'b0;
          end else begin
            sda_d = sda_q;
          end
          if (half_q == HP_LAST) begin
            scl_d   = 1'b1;
            phase_d = 1'b1;
            half_d  = 16'd0;
          end else begin
            half_d = half_q + 16'd1;
          end
        end else begin
          if (half_q == HP_LAST) begin
            sda_d   = 1'b1;
            phase_d = 1'b0;
            half_d  = 16'd0;
            cnt_d   = 32'd0;
            state_d = ST_GAP;
          end else begin
            half_d = half_q + 16'd1;
          end
        end
      end

      ST_GAP: begin
        scl_d = 1'b1;
        sda_d = 1'b1;
        if (cnt_q == GAP_LAST) begin
          done_d   = 1'b1;
          serial_d = serial_q + 32'd1;
          active_d = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        scl_d    = 1'b1;
        sda_d    = 1'b1;
        active_d = 1'b0;
      end
    endcase
  end

  // Two-flop synchroniser for the asynchronous sub-system busy line.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_m_q <= 1'b0;
      busy_s_q <= 1'b0;
    end else begin
      busy_m_q <= ro_busy;
      busy_s_q <= busy_m_q;
    end
  end

  // State and datapath registers; reset drops the bus to idle at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      serial_q   <= 32'h0000_0000;
      id_q       <= 8'h00;
      type_q     <= 8'h00;
      cnt_q      <= 32'd0;
      half_q     <= 16'd0;
      phase_q    <= 1'b0;
      slot_q     <= 4'd0;
      byte_q     <= 3'd0;
      crc_step_q <= CRC_STEP_CLEAR;
      crc_q      <= 16'h0000;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      ack_q      <= 1'b0;
      done_q     <= 1'b0;
      to_q       <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      serial_q   <= serial_d;
      id_q       <= id_d;
      type_q     <= type_d;
      cnt_q      <= cnt_d;
      half_q     <= half_d;
      phase_q    <= phase_d;
      slot_q     <= slot_d;
      byte_q     <= byte_d;
      crc_step_q <= crc_step_d;
      crc_q      <= crc_d;
      scl_q      <= scl_d;
      sda_q      <= sda_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      to_q       <= to_d;
      active_q   <= active_d;
    end
  end

  assign ctl.trig_ack       = ack_q;
  assign ctl.frame_done     = done_q;
  assign ctl.busy_timeout   = to_q;
  assign ctl.tx_active      = active_q;
  assign ctl.trigger_serial = serial_q;

  assign di_sda   = sda_q;
  assign ren_sda  = 1'b1;
  assign de_sda   = 1'b1;
  assign di_scl   = scl_q;
  assign ren_scl  = 1'b1;
  assign de_scl   = 1'b1;
  assign di_busy  = 1'b0;
  assign ren_busy = 1'b0;
  assign de_busy  = 1'b0;

endmodule

// File: tb/tb_trigger_tx.sv
// tb_trigger_tx: scoreboard bench for trigger_tx.
// Stimulus pushes the frame it expects onto exp_q; an independent bus monitor
// decodes SCL/SDA and compares each completed frame against the queue head.
module tb_trigger_tx;

  localparam int HP = 4;
  localparam int BT = 100;
  localparam int GC = 10;

  typedef struct packed {
    logic [7:0]  id;
    logic [7:0]  typ;
    logic [31:0] serial;
  } frame_t;

  logic clk = 1'b0;
  logic reset;
  logic ro_sda, ren_sda, de_sda, di_sda;
  logic ro_scl, ren_scl, de_scl, di_scl;
  logic ro_busy, ren_busy, de_busy, di_busy;

  trigger_tx_if tif ();

  trigger_tx #(.HALF_PERIOD(HP), .BUSY_TIMEOUT(BT), .GAP_CYCLES(GC)) dut (
    .clk(clk), .reset(reset), .ctl(tif),
    .ro_sda(ro_sda), .ren_sda(ren_sda), .de_sda(de_sda), .di_sda(di_sda),
    .ro_scl(ro_scl), .ren_scl(ren_scl), .de_scl(de_scl), .di_scl(di_scl),
    .ro_busy(ro_busy), .ren_busy(ren_busy), .de_busy(de_busy), .di_busy(di_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  frame_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Reference CRC16-KERMIT (reflected poly 0x8408, init 0, no xorout).
  function automatic logic [15:0] kermit(input frame_t f);
    logic [7:0]  msg [6];
    logic [15:0] c;
    msg[0] = f.id;  msg[1] = f.typ;
    msg[2] = f.serial[31:24]; msg[3] = f.serial[23:16];
    msg[4] = f.serial[15:8];  msg[5] = f.serial[7:0];
    c = 16'h0000;
    for (int i = 0; i < 6; i++) begin
      c = c ^ {8'h00, msg[i]};
      for (int b = 0; b < 8; b++) begin
        if (c[0]) c = (c >> 1) ^ 16'h8408;
        else      c = c >> 1;
      end
    end
    return c;
  endfunction

  function automatic logic [7:0] exp_byte(input frame_t f, input int k);
    logic [15:0] c;
    c = kermit(f);
    case (k)
      0: return f.id;
      1: return f.typ;
      2: return f.serial[31:24];
      3: return f.serial[23:16];
      4: return f.serial[15:8];
      5: return f.serial[7:0];
      6: return c[15:8];
      default: return c[7:0];
    endcase
  endfunction

  // ---------------- bus monitor ----------------
  logic        prev_scl = 1'b1;
  logic        prev_sda = 1'b1;
  bit          in_frame = 1'b0;
  int          mon_pulses = 0;
  int          hi_changes = 0;
  int          starts = 0, stops = 0, scl_rises_total = 0;
  int          frames_rx = 0, ack_count = 0, to_count = 0;
  logic [79:0] shreg = 80'h0;

  task automatic finish_frame();
    logic [71:0] d;
    logic [8:0]  dummies;
    frame_t      e;
    d = shreg[72:1];
    check("scl_pulse_count", 32'(mon_pulses - 1), 32'd72);
    check("sda_stable_while_scl_high", 32'(hi_changes), 32'd0);
    check("frame_was_expected", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      dummies = 9'h0;
      for (int k = 0; k < 8; k++) begin
        check($sformatf("frame_byte%0d", k), {24'h0, d[71 - 9*k -: 8]}, {24'h0, exp_byte(e, k)});
        dummies[k] = d[63 - 9*k];
      end
      check("dummy_slots_zero", {23'h0, dummies}, 32'd0);
    end
    frames_rx++;
  endtask

  always @(negedge clk) begin
    if (tif.trig_ack === 1'b1) ack_count++;
    if (tif.busy_timeout === 1'b1) to_count++;
    if (reset) begin
      if (in_frame) begin
        in_frame = 1'b0;
        mon_pulses = 0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end else begin
      if (!prev_scl && di_scl) scl_rises_total++;
      if (!in_frame) begin
        if (prev_scl && di_scl && prev_sda && !di_sda) begin
          in_frame = 1'b1; starts++; mon_pulses = 0; hi_changes = 0; shreg = 80'h0;
        end
      end else if (!prev_scl && di_scl) begin
        mon_pulses++;
        shreg = {shreg[78:0], di_sda};
        if (di_sda !== prev_sda) hi_changes++;
      end else if (prev_scl && di_scl && (di_sda !== prev_sda)) begin
        if (di_sda) begin
          stops++;
          in_frame = 1'b0;
          finish_frame();
          mon_pulses = 0;
        end else begin
          hi_changes++;
        end
      end
    end
    prev_scl = di_scl;
    prev_sda = di_sda;
  end

  // ---------------- stimulus ----------------
  task automatic send_req(input logic [7:0] id, input logic [7:0] typ, input logic clr,
                          input logic [31:0] ser);
    frame_t f;
    @(negedge clk);
    tif.trig_req = 1'b1; tif.sub_system_id = id; tif.trigger_type = typ; tif.serial_clear = clr;
    f.id = id; f.typ = typ; f.serial = ser;
    exp_q.push_back(f);
    @(negedge clk);
    tif.trig_req = 1'b0; tif.serial_clear = 1'b0;
    check("trig_ack", {31'h0, tif.trig_ack}, 32'd1);
    check("tx_active_on_ack", {31'h0, tif.tx_active}, 32'd1);
  endtask

  task automatic wait_done(input string name);
    int c;
    c = 0;
    while (tif.frame_done !== 1'b1 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check(name, {31'h0, tif.frame_done}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_scl"}, {31'h0, di_scl}, 32'd1);
    check({tag, "_sda"}, {31'h0, di_sda}, 32'd1);
    check({tag, "_ack"}, {31'h0, tif.trig_ack}, 32'd0);
    check({tag, "_done"}, {31'h0, tif.frame_done}, 32'd0);
    check({tag, "_timeout"}, {31'h0, tif.busy_timeout}, 32'd0);
    check({tag, "_active"}, {31'h0, tif.tx_active}, 32'd0);
    check({tag, "_serial"}, tif.trigger_serial, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, r0, s0, p0, a0, t0;
    reset = 1'b1;
    tif.trig_req = 1'b0; tif.sub_system_id = 8'h00; tif.trigger_type = 8'h00; tif.serial_clear = 1'b0;
    ro_sda = 1'b0; ro_scl = 1'b0; ro_busy = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    check("ren_sda", {31'h0, ren_sda}, 32'd1);
    check("de_sda", {31'h0, de_sda}, 32'd1);
    check("ren_scl", {31'h0, ren_scl}, 32'd1);
    check("de_scl", {31'h0, de_scl}, 32'd1);
    check("ren_de_di_busy", {29'h0, ren_busy, de_busy, di_busy}, 32'd0);
    reset = 1'b0;

    // Three back-to-back frames carry serials 0,1,2.
    for (int i = 0; i < 3; i++) begin
      send_req(8'h5A, 8'h03, 1'b0, 32'(i));
      wait_done("frame_done_basic");
    end
    check("serial_after_three", tif.trigger_serial, 32'd3);
    check("frames_after_three", 32'(frames_rx), 32'd3);

    // Busy held high: request is dropped after BT cycles, bus untouched.
    ro_busy = 1'b1;
    repeat (4) @(negedge clk);
    r0 = scl_rises_total;
    send_req(8'h11, 8'h22, 1'b0, 32'd3);
    void'(exp_q.pop_back());
    c = 0;
    while (tif.busy_timeout !== 1'b1 && c < 300) begin
      @(negedge clk);
      c++;
    end
    check_range("busy_timeout_latency", c, BT - 2, BT + 2);
    @(negedge clk);
    check("no_scl_during_wait", 32'(scl_rises_total - r0), 32'd0);
    check("serial_after_timeout", tif.trigger_serial, 32'd3);
    check("active_after_timeout", {31'h0, tif.tx_active}, 32'd0);

    // Busy released 50 cycles into the wait: one full frame follows.
    s0 = starts; p0 = stops; t0 = to_count;
    send_req(8'hC3, 8'h81, 1'b0, 32'd3);
    repeat (50) @(negedge clk);
    ro_busy = 1'b0;
    wait_done("frame_done_after_busy");
    check("start_count", 32'(starts - s0), 32'd1);
    check("stop_count", 32'(stops - p0), 32'd1);
    check("no_timeout_when_released", 32'(to_count - t0), 32'd0);

    // Serial preset to all ones, then wrap to zero.
    @(negedge clk);
    force dut.serial_q = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    release dut.serial_q;
    @(negedge clk);
    check("serial_preset", tif.trigger_serial, 32'hFFFF_FFFF);
    send_req(8'h12, 8'h34, 1'b0, 32'hFFFF_FFFF);
    wait_done("frame_done_wrap");
    check("serial_wrapped", tif.trigger_serial, 32'd0);

    // A second request mid-frame is ignored.
    send_req(8'hA5, 8'h5A, 1'b0, 32'd0);
    repeat (60) @(negedge clk);
    a0 = ack_count;
    tif.trig_req = 1'b1; tif.sub_system_id = 8'hFF; tif.trigger_type = 8'hFF;
    @(negedge clk);
    tif.trig_req = 1'b0;
    repeat (3) @(negedge clk);
    check("ignored_request_no_ack", 32'(ack_count - a0), 32'd0);
    wait_done("frame_done_ignored_req");
    send_req(8'h01, 8'h02, 1'b0, 32'd1);
    wait_done("frame_done_after_ignored");
    check("serial_after_ignored", tif.trigger_serial, 32'd2);

    // Reset at SCL pulse 30 aborts the frame; the next frame is clean.
    send_req(8'h77, 8'h88, 1'b0, 32'd2);
    c = 0;
    while (!(in_frame && mon_pulses >= 30) && c < 1000) begin
      @(negedge clk);
      c++;
    end
    check_range("reached_pulse_30", mon_pulses, 30, 30);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midframe_reset");
    @(negedge clk);
    reset = 1'b0;
    check("abort_discarded", 32'(exp_q.size()), 32'd0);
    send_req(8'h5A, 8'h03, 1'b0, 32'd0);
    wait_done("frame_done_after_reset");
    check("serial_after_reset_frame", tif.trigger_serial, 32'd1);

    // Clear and request together: frame carries serial 0.
    send_req(8'h3C, 8'hC3, 1'b1, 32'd0);
    wait_done("frame_done_clear");
    check("serial_after_clear", tif.trigger_serial, 32'd1);

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("frames_total", 32'(frames_rx), 32'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trigger_tx.md
Name: trigger_tx

Overview:
- Master/transmitter end of the DI2C trigger-synchronisation link; one instance per trigger source, fanning out to sub-system receivers over RS-485-style transceivers.
- On a trigger request it:
  - waits for the sub-system busy line to be low;
  - computes a CRC16-KERMIT over the payload;
  - serialises start, 8 bytes and stop onto SCL/SDA.
- Maintains the 32-bit trigger serial counter that numbers every sent frame.

Parameters:
- HALF_PERIOD, 50, clk cycles per SCL half-period (SCL freq = f_clk / (2*HALF_PERIOD)); legal range 4..65535.
- BUSY_TIMEOUT, 1000000, clk cycles a pending request may wait on busy before it is dropped.
- GAP_CYCLES, 200, minimum idle cycles (SCL=SDA=1) after a stop before the next start.

Ports:
- clk  in  1  system clock, 10-100 MHz.
- reset  in  1  synchronous, active-high.
- trig_req  in  1  single-cycle request to send a trigger.
- sub_system_id  in  8  sampled when a request is accepted.
- trigger_type  in  8  sampled when a request is accepted.
- serial_clear  in  1  synchronous clear of the serial counter; honoured only in IDLE.
- trig_ack  out  1  1-cycle pulse when a request is accepted.
- frame_done  out  1  1-cycle pulse after the stop condition completes.
- busy_timeout  out  1  1-cycle pulse when a pending request is dropped.
- tx_active  out  1  high from acceptance to the end of the gap.
- trigger_serial  out  32  serial number the next frame will carry.
- ro_sda/ren_sda/de_sda/di_sda  in/out/out/out  1 each  SDA transceiver; ren=1, de=1, di=SDA level, ro ignored.
- ro_scl/ren_scl/de_scl/di_scl  in/out/out/out  1 each  SCL transceiver; ren=1, de=1, di=SCL level, ro ignored.
- ro_busy/ren_busy/de_busy/di_busy  in/out/out/out  1 each  busy transceiver; ren=0, de=0, di=0, ro_busy = sub-system busy input.

Behaviour:
- Reset values:
  - SCL=1, SDA=1.
  - trig_ack, frame_done, busy_timeout and tx_active = 0.
  - trigger_serial = 0.
  - State = IDLE.
  - Reset mid-frame aborts immediately and returns the lines to 1/1 on the next cycle; no stop is generated.
- ro_busy passes through a 2-flop synchroniser; busy_s is the synchronised value.
- Requests:
  - trig_req is honoured only in IDLE. Requests arriving in any other state are ignored, with no queuing.
  - Acceptance means trig_ack=1 in the next cycle and id/type are latched.
  - If trig_req and serial_clear arrive in the same cycle, the clear applies first and the frame carries serial 0.
- State machine:
  - IDLE -> WAIT_BUSY on request.
  - WAIT_BUSY:
    - If busy_s=0 -> CRC.
    - If the wait counter reaches BUSY_TIMEOUT -> busy_timeout pulse, return to IDLE, serial unchanged.
  - CRC:
    - Pulse the crc16_generator reset, then present three 16-bit words on 3 consecutive cycles: {id,type}, serial[31:16], serial[15:0].
    - Each word is presented bit-reversed within each byte, keeping byte order: data_in = {w[8..15], w[0..7]}.
    - crc_out is latched 1 cycle after the last enable.
    - Then -> START.
  - START: SDA=0 while SCL=1 for one half-period; then SCL=0 -> BITS.
  - BITS: 8 bytes sent in order: id, type, serial[31:24], [23:16], [15:8], [7:0], crc[15:8], crc[7:0].
    - Bits go MSB first.
    - Each byte takes 9 SCL pulses; the 9th is a dummy with SDA=0. Total 72 pulses.
    - Per pulse: SDA changes only in the first cycle of the SCL-low half-period; SCL is low for HALF_PERIOD cycles, then high for HALF_PERIOD cycles.
  - STOP: SCL low with SDA=0 for a half-period, then SCL=1 for a half-period, then SDA=1 (rising edge while SCL high) -> GAP.
  - GAP: hold 1/1 for GAP_CYCLES, then frame_done pulse and trigger_serial+1 (wraps 0xFFFFFFFF -> 0) -> IDLE.
- Busy rising during a frame is ignored; the sub-system raises busy itself on the start condition.
- SDA never changes while SCL is high except at start and stop.
- Outputs are registered with no combinational path from inputs; di_scl and di_sda come straight from flops.
- Latency, request to SDA fall, with busy low: 1 (accept) + 2 (sync) + 5 (CRC) cycles, ±1.

Decomposition:
- Shared package trigger_pkg:
  - state encodings;
  - FRAME_BYTES=8, BITS_PER_BYTE_SLOT=9;
  - byte-order constants;
  - CRC byte-bit-reversal mapping, so that trigger_tx and trigger_rx use an identical definition.
- Sub-module: reuse the existing crc16_generator (clock, reset, data_in_en, data_in[15:0], crc_out[15:0]); no new sub-module.

Test Plan:
- Loopback into a trigger_rx instance with busy_clear pulsed after each frame:
  - id=0x5A, type=0x03, three requests -> rx receives serials 0, 1, 2 with crc_status=1 each time;
  - trigger_serial ends at 3.
- Hold ro_busy=1 with BUSY_TIMEOUT=100 and request -> busy_timeout pulses exactly 100±2 cycles after trig_ack; no SCL activity; serial unchanged.
- Release busy at cycle 50 of the wait -> frame starts; bus monitor counts 72 SCL pulses, 1 start, 1 stop, and sees no SDA change while SCL=1 mid-frame.
- Preset serial to 0xFFFFFFFF via repeated frames/force, then send one frame -> transmitted serial bytes are FF FF FF FF and trigger_serial=0 afterwards.
- Second trig_req during BITS -> ignored (no trig_ack); after frame_done plus a new request, a second frame is sent.
- Assert reset at SCL pulse 30 -> SCL=SDA=1 next cycle; all outputs at reset values; the next frame is decoded correctly by the rx.
